// File: rtl/dl11_pkg.sv
// dl11_pkg: shared definitions for the DL11 console register block.
//   - register word addresses on the 2-bit bus_addr
//   - bit positions inside the CSR and RBUF words
//   - RX and TX handshake FSM state encodings
//   - helpers that assemble the CSR and RBUF read words
package dl11_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ADDR_RCSR = 2'd0;
  localparam logic [1:0] ADDR_RBUF = 2'd1;
  localparam logic [1:0] ADDR_XCSR = 2'd2;
  localparam logic [1:0] ADDR_XBUF = 2'd3;

  localparam int BIT_DONE  = 7;
  localparam int BIT_READY = 7;
  localparam int BIT_IE    = 6;
  localparam int BIT_OVR   = 14;
  localparam int BIT_ERR   = 15;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_REQ  = 2'd1,
    T_BUSY = 2'd2
  } tx_state_t;

  // RCSR / XCSR layout: status flag in bit 7, interrupt enable in bit 6.
  function automatic logic [15:0] csr_word(input logic flag, input logic ie);
    logic [15:0] w;
    w            = '0;
    w[BIT_DONE]  = flag;
    w[BIT_IE]    = ie;
    return w;
  endfunction

  // RBUF layout: received byte in the low byte (0 when nothing is held),
  // overrun reported on both OVR and the summary ERR bit.
  function automatic logic [15:0] rbuf_word(input logic             valid,
                                            input logic [DATA_W-1:0] head,
                                            input logic             ovr);
    logic [15:0] w;
    w           = '0;
    w[7:0]      = valid ? head : '0;
    w[BIT_OVR]  = ovr;
    w[BIT_ERR]  = ovr;
    return w;
  endfunction

endpackage

// File: rtl/dl11_rx_fifo.sv
// dl11_rx_fifo: small synchronous FIFO holding bytes received from uart_rx.
//   clk, reset_n : clock, asynchronous active-low reset (pointers and count)
//   push, din    : write request and byte; ignored while full
//   pop          : read request; ignored while empty
//   full, empty  : occupancy flags
//   head         : oldest entry, valid while !empty
// A pop in the same cycle as a push on a full FIFO does not make room for
// that push: the push is judged against the occupancy before the pop.
module dl11_rx_fifo #(
  parameter int RX_FIFO_DEPTH = 4,
  parameter int RX_FIFO_AW    = 2,
  parameter int DATA_W        = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam logic [RX_FIFO_AW:0] DEPTH_C = (RX_FIFO_AW + 1)'(RX_FIFO_DEPTH);

  logic [DATA_W-1:0]   mem [RX_FIFO_DEPTH];
  logic [RX_FIFO_AW-1:0] wr_ptr;
  logic [RX_FIFO_AW-1:0] rd_ptr;
  logic [RX_FIFO_AW:0]   count;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dl11_console.sv
// dl11_console: PDP-11 DL11-style console register block.
// Registers (word address on bus_addr):
//   0 RCSR : bit7 DONE (FIFO non-empty, RO), bit6 IE (RW)
//   1 RBUF : bits7:0 FIFO head (read pops), bit14 OVR, bit15 ERR
//   2 XCSR : bit7 READY (RO), bit6 IE (RW)
//   3 XBUF : write-only transmit byte
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   bus_sel/bus_wr/bus_addr/bus_be/bus_wdata : one-cycle register access
//   bus_rdata             : read data, registered, valid the cycle after bus_sel
//   rx_data/rx_data_ready/rx_clear : uart_rx byte handshake
//   tx_data/tx_send/tx_ready       : uart_tx byte handshake
//   rx_irq, tx_irq        : level interrupts
// Build option: define DL11_RX_OVERRUN_EN to record bytes dropped on a full
// FIFO as a sticky overrun flag shown in RBUF bits 15:14; otherwise drops
// are silent and those bits read 0.
module dl11_console
  import dl11_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 4,
  parameter int RX_FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_sel,
  input  logic        bus_wr,
  input  logic [1:0]  bus_addr,
  input  logic [1:0]  bus_be,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  output logic        rx_clear,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_ready,
  output logic        rx_irq,
  output logic        tx_irq
);

  rx_state_t         rx_state;
  tx_state_t         tx_state;
  logic              rx_ie;
  logic              tx_ie;
  logic              ovr;

  logic              bus_rd;
  logic              bus_wr_lo;
  logic              rbuf_rd;
  logic              xbuf_wr;
  logic              tx_rdy_bit;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              rx_drop;
  logic [15:0]       rdata_nxt;
  logic              unused_ok;

  // High byte of writes carries nothing in this block.
  assign bus_rd     = bus_sel & ~bus_wr;
  assign bus_wr_lo  = bus_sel & bus_wr & bus_be[0];
  assign rbuf_rd    = bus_rd & (bus_addr == ADDR_RBUF);
  assign xbuf_wr    = bus_wr_lo & (bus_addr == ADDR_XBUF);
  assign tx_rdy_bit = (tx_state == T_IDLE) & tx_ready;

  assign fifo_push  = (rx_state == R_IDLE) & rx_data_ready;
  assign fifo_pop   = rbuf_rd & ~fifo_empty;
  assign rx_drop    = fifo_push & fifo_full;

  assign rx_irq     = rx_ie & ~fifo_empty;
  assign tx_irq     = tx_ie & tx_rdy_bit;

  assign unused_ok  = &{1'b0, bus_wdata[15:8], bus_be[1], rx_drop};

  dl11_rx_fifo #(
    .RX_FIFO_DEPTH (RX_FIFO_DEPTH),
    .RX_FIFO_AW    (RX_FIFO_AW),
    .DATA_W        (DATA_W)
  ) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (rx_data),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // RX handshake: one push attempt per rx_data_ready assertion; R_ACK waits
  // for the flag to fall so a slowly clearing flag is not seen twice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= R_IDLE;
      rx_clear <= 1'b0;
    end else begin
      rx_clear <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (rx_data_ready) begin
            rx_clear <= 1'b1;
            rx_state <= R_ACK;
          end
        end
        R_ACK: begin
          if (!rx_data_ready) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // TX handshake: hold tx_send until uart_tx reports busy, then wait for
  // it to go idle again before accepting the next XBUF write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= T_IDLE;
      tx_send  <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (xbuf_wr && tx_ready) begin
            tx_data  <= bus_wdata[7:0];
            tx_send  <= 1'b1;
            tx_state <= T_REQ;
          end
        end
        T_REQ: begin
          if (!tx_ready) begin
            tx_send  <= 1'b0;
            tx_state <= T_BUSY;
          end
        end
        T_BUSY: begin
          if (tx_ready) tx_state <= T_IDLE;
        end
        default: begin
          tx_send  <= 1'b0;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
    end else if (bus_wr_lo) begin
      if (bus_addr == ADDR_RCSR) rx_ie <= bus_wdata[BIT_IE];
      if (bus_addr == ADDR_XCSR) tx_ie <= bus_wdata[BIT_IE];
    end
  end

`ifdef DL11_RX_OVERRUN_EN
  // A drop coinciding with the clearing read wins, so no overrun is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ovr <= 1'b0;
    else if (rx_drop) ovr <= 1'b1;
    else if (rbuf_rd) ovr <= 1'b0;
  end
`else
  assign ovr = 1'b0;
`endif

  // RBUF returns the pre-pop head: the word is formed before the pop edge.
  always_comb begin
    rdata_nxt = '0;
    case (bus_addr)
      ADDR_RCSR: rdata_nxt = csr_word(~fifo_empty, rx_ie);
      ADDR_RBUF: rdata_nxt = rbuf_word(~fifo_empty, fifo_head, ovr);
      ADDR_XCSR: rdata_nxt = csr_word(tx_rdy_bit, tx_ie);
      default:   rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    bus_rdata <= '0;
    else if (bus_rd) bus_rdata <= rdata_nxt;
  end

endmodule

// File: tb/tb_dl11_console.sv
module tb_dl11_console;

  localparam int DEPTH = 4;
`ifdef DL11_RX_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bus_sel;
  logic        bus_wr;
  logic [1:0]  bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic [7:0]  rx_data;
  logic        rx_data_ready;
  logic        rx_clear;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_ready;
  logic        rx_irq;
  logic        tx_irq;

  always #5 clk = ~clk;

  dl11_console #(.RX_FIFO_DEPTH(DEPTH), .RX_FIFO_AW(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus_sel       (bus_sel),
    .bus_wr        (bus_wr),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .rx_clear      (rx_clear),
    .tx_data       (tx_data),
    .tx_send       (tx_send),
    .tx_ready      (tx_ready),
    .rx_irq        (rx_irq),
    .tx_irq        (tx_irq)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model of the receive side: a queue of held bytes, the RCSR
  // enable and the sticky overrun flag.
  logic [7:0] rxq[$];
  bit         m_rx_ie;
  bit         m_ovr;

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    bit          exp_rx_irq;
    bit          exp_tx_irq;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [15:0] d);
    @(negedge clk);
    bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = addr; bus_be = 2'b00;
    @(negedge clk);
    bus_sel = 1'b0;
    d = bus_rdata;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [1:0] be, input logic [15:0] wd);
    @(negedge clk);
    bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = addr; bus_be = be; bus_wdata = wd;
    if (addr == 2'd0 && be[0]) m_rx_ie = wd[6];
    @(negedge clk);
    bus_sel = 1'b0; bus_wr = 1'b0;
  endtask

  // uart_rx model: raise the flag, wait (bounded) for the clear pulse, keep
  // the flag up one more cycle to exercise the double-push guard.
  task automatic deliver(input logic [7:0] b, input bit drop_after);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    rx_data = b; rx_data_ready = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = rx_clear;
    end
    check("rx_clear_seen", 16'(seen), 16'd1);
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else if (OVR_EN) m_ovr = 1'b1;
    if (drop_after) begin
      @(negedge clk);
      check("rx_clear_width", 16'(rx_clear), 16'd0);
      rx_data_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic model_rbuf(output logic [15:0] v);
    v = '0;
    if (rxq.size() > 0) v[7:0] = rxq.pop_front();
    v[14] = m_ovr;
    v[15] = m_ovr;
    m_ovr = 1'b0;
  endtask

  task automatic read_rbuf_check(input string name);
    logic [15:0] act, exp;
    bus_read(2'd1, act);
    model_rbuf(exp);
    check(name, act, exp);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    rx_data_ready = 1'b0;
    reset_n = 1'b1;
    rxq.delete();
    m_rx_ie = 1'b0;
    m_ovr   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [15:0] exp;

    reset_n = 1'b0; bus_sel = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_be = '0;
    bus_wdata = '0; rx_data = '0; rx_data_ready = 1'b0; tx_ready = 1'b1;
    m_rx_ie = 1'b0; m_ovr = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_rdata", bus_rdata, 16'h0);
    check("rst_outs", {11'b0, rx_clear, tx_send, rx_irq, tx_irq, 1'b0}, 16'h0);
    check("rst_tx_data", {8'h0, tx_data}, 16'h0);
    reset_n = 1'b1;

    // Register map table: {wr, addr, be, wdata, exp_rdata, rx_irq, tx_irq}
    tbl[0]  = '{1'b0, 2'd0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 2'b00, 16'h0000, 16'h0080, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'd3, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2'd0, 2'b01, 16'h0040, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 2'b00, 16'h0000, 16'h0040, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 2'b10, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'd2, 2'b00, 16'h0000, 16'h0080, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'd2, 2'b11, 16'h0040, 16'h0000, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 2'd2, 2'b00, 16'h0000, 16'h00C0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 2'd0, 2'b01, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 2'd2, 2'b01, 16'hFFBF, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'd2, 2'b00, 16'h0000, 16'h0080, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].be, tbl[i].wdata);
      else begin
        bus_read(tbl[i].addr, d);
        check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rdata);
      end
      check($sformatf("tbl%0d_irq", i), {14'b0, rx_irq, tx_irq},
            {14'b0, tbl[i].exp_rx_irq, tbl[i].exp_tx_irq});
    end

    // Single receive with interrupt
    deliver(8'h41, 1'b1);
    bus_write(2'd0, 2'b01, 16'h0040);
    check("rx1_irq_on", 16'(rx_irq), 16'd1);
    bus_read(2'd0, d);
    check("rx1_rcsr", d, 16'h00C0);
    read_rbuf_check("rx1_rbuf");
    check("rx1_rbuf_const", d, 16'h00C0);
    bus_read(2'd0, d);
    check("rx1_rcsr_after", d, 16'h0040);
    check("rx1_irq_off", 16'(rx_irq), 16'd0);

    // Overflow: five bytes into a depth-4 FIFO
    for (int b = 8'h31; b <= 8'h35; b++) deliver(8'(b), 1'b1);
    for (int k = 0; k < 4; k++) begin
      bus_read(2'd1, d);
      model_rbuf(exp);
      exp = (k == 0 && OVR_EN) ? 16'hC031 : 16'(8'h31 + k);
      check($sformatf("ovf_rbuf%0d", k), d, exp);
    end
    bus_read(2'd1, d);
    check("ovf_rbuf_empty", d, 16'h0000);

    // Transmit path
    tx_ready = 1'b1;
    bus_write(2'd3, 2'b01, 16'h0058);
    check("tx_data", {8'h0, tx_data}, 16'h0058);
    check("tx_send_req", 16'(tx_send), 16'd1);
    bus_read(2'd2, d);
    check("tx_xcsr_req", d, 16'h0000);
    bus_write(2'd3, 2'b01, 16'h0059);
    check("tx_req_ignore", {8'h0, tx_data}, 16'h0058);
    check("tx_send_hold", 16'(tx_send), 16'd1);
    @(negedge clk);
    tx_ready = 1'b0;
    @(negedge clk);
    check("tx_send_drop", 16'(tx_send), 16'd0);
    bus_read(2'd2, d);
    check("tx_xcsr_busy", d, 16'h0000);
    bus_write(2'd3, 2'b01, 16'h0059);
    check("tx_busy_ignore", {8'h0, tx_data}, 16'h0058);
    check("tx_busy_nosend", 16'(tx_send), 16'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    bus_read(2'd2, d);
    check("tx_xcsr_idle", d, 16'h0080);
    bus_write(2'd2, 2'b01, 16'h0040);
    check("tx_irq_on", 16'(tx_irq), 16'd1);
    bus_write(2'd2, 2'b01, 16'h0000);

    // Reset during T_REQ and R_ACK
    bus_write(2'd3, 2'b01, 16'h005A);
    bus_write(2'd0, 2'b01, 16'h0040);
    deliver(8'h77, 1'b0);
    bus_read(2'd0, d);
    check("mid_rcsr", d, 16'h00C0);
    check("mid_tx_send", 16'(tx_send), 16'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_rdata", bus_rdata, 16'h0);
    check("arst_outs", {11'b0, rx_clear, tx_send, rx_irq, tx_irq, 1'b0}, 16'h0);
    check("arst_tx_data", {8'h0, tx_data}, 16'h0);
    apply_reset();
    bus_read(2'd0, d);
    check("post_rcsr", d, 16'h0000);
    bus_read(2'd2, d);
    check("post_xcsr", d, 16'h0080);
    deliver(8'h42, 1'b1);
    read_rbuf_check("post_rbuf");

    // Randomized receive-side traffic against the model
    apply_reset();
    for (int n = 0; n < 250; n++) begin
      int op;
      op = $urandom_range(0, 4);
      case (op)
        0, 1: deliver(8'($urandom), 1'b1);
        2: read_rbuf_check("rnd_rbuf");
        3: begin
          bus_read(2'd0, d);
          exp = {8'h0, rxq.size() != 0, m_rx_ie, 6'b0};
          check("rnd_rcsr", d, exp);
        end
        default: bus_write(2'd0, 2'($urandom), 16'($urandom));
      endcase
      check("rnd_rx_irq", 16'(rx_irq), 16'(m_rx_ie && rxq.size() != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dl11_console.md
Name: dl11_console

Overview:
- PDP-11 DL11-style console register block (RCSR/RBUF/XCSR/XBUF), the host-side consumer of the serial receiver and producer for the serial transmitter.
- Bridges CPU bus register accesses to the uart_rx handshake (rx_data_ready/rx_clear) and the uart_tx handshake (tx_send/tx_ready).
- Buffers received bytes in a small FIFO and raises level interrupts for receive-done and transmit-ready.

Parameters:
- RX_FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16
- RX_FIFO_AW, 2, FIFO address width; equals log2(RX_FIFO_DEPTH)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- bus_sel  in  1  register access strobe, one cycle per access
- bus_wr  in  1  1 = write, 0 = read (qualified by bus_sel)
- bus_addr  in  2  word select: 0 RCSR, 1 RBUF, 2 XCSR, 3 XBUF
- bus_be  in  2  byte enables for writes; bit0 = low byte
- bus_wdata  in  16  write data
- bus_rdata  out  16  read data, registered
- rx_data  in  8  byte from uart_rx
- rx_data_ready  in  1  uart_rx byte-available flag (level)
- rx_clear  out  1  one-cycle pulse clearing rx_data_ready
- tx_data  out  8  byte to uart_tx
- tx_send  out  1  transmit request (level)
- tx_ready  in  1  uart_tx idle
- rx_irq  out  1  RCSR.IE & RCSR.DONE
- tx_irq  out  1  XCSR.IE & XCSR.READY

Behaviour:
- Reset values: bus_rdata=0, rx_clear=0, tx_data=0, tx_send=0, rx_irq=0, tx_irq=0. Both IE bits are 0, the FIFO is empty, and both FSMs are idle. Reset mid-transfer abandons the transfer. tx_send drops at once, so uart_tx finishes its frame and then returns to idle.
- Register map:
  - RCSR: bit7 DONE = FIFO non-empty (read-only); bit6 IE (R/W, low byte only); other bits read 0.
  - RBUF: bits7:0 = FIFO head (0 when empty); bit14 OVR (optional feature); others 0.
  - XCSR: bit7 READY (read-only); bit6 IE (R/W); others 0.
  - XBUF: write-only; reads return 0.
- Read latency: bus_rdata is valid on the cycle after bus_sel. It holds its value until the next read.
- RBUF read pops the FIFO in the bus_sel cycle, and the returned value is the pre-pop head. RBUF read while empty returns 0 and does not pop.
- Writes with bus_be[0]=0 are ignored for all registers.
- RX FSM (R_IDLE, R_ACK):
  - In R_IDLE with rx_data_ready=1: push rx_data if the FIFO is not full, otherwise drop it. Either way, pulse rx_clear for one cycle and go to R_ACK.
  - In R_ACK: stay until rx_data_ready=0, then return to R_IDLE. This prevents a double push while the flag is still falling.
- Simultaneous push and RBUF pop are both performed; the count is unchanged. On a full FIFO, a pop in the same cycle does not make room for that push; the byte is dropped.
- TX FSM (T_IDLE, T_REQ, T_BUSY):
  - READY = (state==T_IDLE) & tx_ready.
  - XBUF write with READY=1: latch tx_data = bus_wdata[7:0] and go to T_REQ.
  - T_REQ: tx_send=1 until tx_ready=0, then T_BUSY with tx_send=0.
  - T_BUSY: wait for tx_ready=1, then T_IDLE.
  - An XBUF write with READY=0 is ignored; tx_data is unchanged.
- Interrupts are combinational from the registered bits. A write setting IE while DONE/READY=1 asserts the irq on the next cycle.
- FIFO pointers wrap modulo RX_FIFO_DEPTH. The count is RX_FIFO_AW+1 bits, and full = (count==RX_FIFO_DEPTH).

Optional Feature:
- Macro: DL11_RX_OVERRUN_EN.
- Defined: a byte dropped on a full FIFO sets a sticky ovr flag. RBUF reads show it as bit14 OVR and bit15 ERR (=OVR). The flag clears on the next RBUF read; a drop in the same cycle as that read keeps it set.
- Undefined: drops are silent, and RBUF bits15:14 read 0.

Decomposition:
- Package dl11_pkg: register word addresses (RCSR=0, RBUF=1, XCSR=2, XBUF=3), bit positions (DONE/READY=7, IE=6, OVR=14, ERR=15), and RX/TX FSM state encodings.
- Sub-module: dl11_rx_fifo, a synchronous FIFO with push/pop/full/empty/head, asynchronous active-low reset, parameterised by RX_FIFO_DEPTH/RX_FIFO_AW.

Test Plan:
- Reset, then read RCSR and XCSR with tx_ready=1 -> RCSR=0x0000, XCSR=0x0080, no irq.
- rx_data=0x41 with rx_data_ready high until rx_clear, write RCSR=0x0040 -> single rx_clear pulse, RCSR=0x00C0, rx_irq=1. RBUF read returns 0x0041, then RCSR=0x0040 and rx_irq=0.
- Deliver 5 bytes 0x31..0x35 with depth 4, then 4 RBUF reads -> 0x31..0x34. The fifth byte is dropped (rx_clear still pulsed). With DL11_RX_OVERRUN_EN, the first read is 0xC031 and the later reads have no error bits.
- Write XBUF=0x0058 with tx_ready=1 and a uart_tx model -> tx_data=0x58 and tx_send high until tx_ready falls, then low. XCSR reads 0x0000 while busy and 0x0080 after.
- XBUF=0x0059 written while busy -> ignored; only 0x58 is transmitted.
- Assert reset_n=0 mid-T_REQ and mid-R_ACK -> all outputs 0 asynchronously and the FIFO empty. Normal operation resumes after release.
